// File: rtl/i2s_capture.sv
// i2s_capture: I2S master receiver capturing one channel of a MEMS microphone stream
module i2s_capture #(
  parameter int DATA_SIZE = 24,
  parameter int CLK_DIV   = 4,
  parameter int CHANNEL   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sd_in,
  output logic                 sck,
  output logic                 ws,
  output logic                 ready_i2s,
  output logic [DATA_SIZE-1:0] audio_data_out
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int SW = DATA_SIZE > 1 ? DATA_SIZE - 1 : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SYNC = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  logic [1:0] state;
  logic [DW-1:0] div_cnt;
  logic [5:0] bit_cnt, bit_nxt;
  logic sd_m, sd_s;
  logic [SW-1:0] shift;
  logic [DATA_SIZE-1:0] shift_nxt;
  logic tick, rise, fall, slot_ok, out_ev;
  // divider terminal count, sck edge events and capture window decode
  always_comb begin
    tick = state != IDLE && div_cnt == DW'(CLK_DIV - 1);
    rise = tick && !sck;
    fall = tick && sck;
    bit_nxt = bit_cnt + 6'd1;
    slot_ok = ws == 1'(CHANNEL) && bit_cnt[4:0] != 5'd0 && bit_cnt[4:0] <= 5'(DATA_SIZE);
    shift_nxt = DATA_SIZE'({shift, sd_s});
    out_ev = rise && slot_ok && bit_cnt[4:0] == 5'(DATA_SIZE) && state == RUN;
  end
  // two-flop synchroniser for the asynchronous microphone data
  always_ff @(posedge clk) begin
    if (rst) {sd_m, sd_s} <= 2'b00;
    else {sd_m, sd_s} <= {sd_in, sd_m};
  end
  // state machine, sck/ws generation and serial shift; dropping en aborts the frame
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      sck <= 1'b0;
      ws <= 1'b0;
      shift <= '0;
    end else begin
      state <= state == IDLE ? SYNC : (state == SYNC && fall && bit_cnt == 6'd63) ? RUN : state;
      div_cnt <= (tick || state == IDLE) ? '0 : div_cnt + DW'(1);
      sck <= tick ? !sck : sck;
      bit_cnt <= fall ? bit_nxt : bit_cnt;
      ws <= fall ? bit_nxt[5] : ws;
      shift <= (rise && slot_ok) ? shift_nxt[SW-1:0] : shift;
    end
  end
  // present the completed word with a one-cycle strobe; idle keeps the last sample
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_i2s <= 1'b0;
      audio_data_out <= '0;
    end else begin
      ready_i2s <= en && out_ev;
      audio_data_out <= (en && out_ev) ? shift_nxt : audio_data_out;
    end
  end
endmodule

// File: tb/tb_i2s_capture.sv
// tb_i2s_capture: microphone model plus scoreboard for both capture channels
`timescale 1ns/1ps
module tb_i2s_capture;
  localparam int N = 5;
  typedef struct { logic [23:0] l, r, exp_l, exp_r; } vec_t;
  vec_t vecs [N];
  logic clk = 0, rst = 1, en = 1, sd = 0, rst_q = 1;
  logic sck_l, ws_l, rdy_l, sck_r, ws_r, rdy_r;
  logic [23:0] dat_l, dat_r, prv_l = 0, prv_r = 0, hl, hr, word = 0;
  logic [23:0] q_l[$], q_r[$];
  logic prev_sck = 0, mic_on = 0, prev_ws = 0;
  int cyc = 0, total = 0, bad = 0;
  int first_rise = -1, last_l = -1, last_r = -1, np_l = 0, np_r = 0;
  int idx = 0, falls = 0, k = 0;

  i2s_capture #(.DATA_SIZE(24), .CLK_DIV(4), .CHANNEL(0)) u_l (
    .clk(clk), .rst(rst), .en(en), .sd_in(sd),
    .sck(sck_l), .ws(ws_l), .ready_i2s(rdy_l), .audio_data_out(dat_l));
  i2s_capture #(.DATA_SIZE(24), .CLK_DIV(4), .CHANNEL(1)) u_r (
    .clk(clk), .rst(rst), .en(en), .sd_in(sd),
    .sck(sck_r), .ws(ws_r), .ready_i2s(rdy_r), .audio_data_out(dat_r));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // I2S slave: realigns on every ws change, MSB one slot after the change
  always @(negedge sck_l) begin
    #1;
    if (ws_l != prev_ws) begin
      idx = 0;
      if (!ws_l) falls++;
      word = ws_l ? vecs[k % N].r : vecs[k % N].l;
      if (mic_on && falls > 0) begin
        if (ws_l) begin
          q_r.push_back(vecs[k % N].exp_r);
          k++;
        end else q_l.push_back(vecs[k % N].exp_l);
      end
    end else idx++;
    prev_ws = ws_l;
    sd = (idx >= 1 && idx <= 24) ? word[24 - idx] : 1'b0;
  end

  always @(negedge clk) begin
    if (sck_l && !prev_sck && first_rise < 0) first_rise = cyc;
    prev_sck = sck_l;
    if (!rst_q && !rdy_l) check("hold_l", dat_l, prv_l);
    if (!rst_q && !rdy_r) check("hold_r", dat_r, prv_r);
    if (rdy_l) begin
      if (q_l.size() == 0) begin
        total++; bad++;
        $display("FAIL pulse_l: unexpected pulse data %0h want none (cyc %0d)", dat_l, cyc);
      end else check("data_l", dat_l, q_l.pop_front());
      if (last_l < 0) check("first_l", cyc - first_rise, 704);
      else check("gap_l", cyc - last_l, 512);
      last_l = cyc;
      np_l++;
    end
    if (rdy_r) begin
      if (q_r.size() == 0) begin
        total++; bad++;
        $display("FAIL pulse_r: unexpected pulse data %0h want none (cyc %0d)", dat_r, cyc);
      end else check("data_r", dat_r, q_r.pop_front());
      if (last_r < 0) check("first_r", cyc - first_rise, 960);
      else check("gap_r", cyc - last_r, 512);
      last_r = cyc;
      np_r++;
    end
    prv_l = dat_l;
    prv_r = dat_r;
  end

  task automatic restart();
    q_l.delete(); q_r.delete();
    idx = 0; falls = 0; k = 0; prev_ws = 0;
    first_rise = -1; last_l = -1; last_r = -1; np_l = 0; np_r = 0;
    mic_on = 1;
  endtask

  task automatic startup();
    int n = 0;
    while (!sck_l && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("startup", n, 5);
  endtask

  task automatic wait_pulses(input int n);
    for (int i = 0; i < 20000 && !(np_l >= n && np_r >= n); i++) @(negedge clk);
    check("pulse_wait", {31'd0, np_l >= n && np_r >= n}, 1);
  endtask

  task automatic wait_slot(input int s, input logic left_only);
    for (int i = 0; i < 2000 && !(falls > 0 && idx == s && (!left_only || !ws_l)); i++) @(negedge clk);
    check("slot_found", idx, s);
  endtask

  initial begin
    vecs[0] = '{24'hA5C3F1, 24'h123456, 24'hA5C3F1, 24'h123456};
    vecs[1] = '{24'h800000, 24'h7FFFFF, 24'h800000, 24'h7FFFFF};
    vecs[2] = '{24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000};
    vecs[3] = '{24'h000001, 24'hFFFFFF, 24'h000001, 24'hFFFFFF};
    vecs[4] = '{24'h000000, 24'h5A5A5A, 24'h000000, 24'h5A5A5A};
    repeat (5) begin
      @(negedge clk);
      check("rst_sck", sck_l, 0);
      check("rst_ws", ws_l, 0);
      check("rst_rdy", rdy_l | rdy_r, 0);
      check("rst_dat", dat_l | dat_r, 0);
    end
    rst = 0;
    restart();
    startup();
    for (int i = 0; i < N; i++) begin
      wait_pulses(i + 1);
      check("vec_l", dat_l, vecs[i].exp_l);
      check("vec_r", dat_r, vecs[i].exp_r);
    end
    wait_slot(10, 1'b1);
    en = 0;
    mic_on = 0;
    q_l.delete(); q_r.delete();
    hl = dat_l;
    hr = dat_r;
    @(negedge clk);
    check("drop_sck", sck_l, 0);
    check("drop_ws", ws_l, 0);
    repeat (99) @(negedge clk);
    check("idle_sck", sck_l, 0);
    check("idle_dat_l", dat_l, hl);
    check("idle_dat_r", dat_r, hr);
    en = 1;
    restart();
    startup();
    wait_pulses(2);
    wait_slot(20, 1'b0);
    rst = 1;
    mic_on = 0;
    q_l.delete(); q_r.delete();
    @(negedge clk);
    check("mrst_dat_l", dat_l, 0);
    check("mrst_dat_r", dat_r, 0);
    check("mrst_sck", sck_l, 0);
    check("mrst_ws", ws_l, 0);
    check("mrst_rdy", rdy_l | rdy_r, 0);
    rst = 0;
    restart();
    startup();
    wait_pulses(1);
    check("fresh_l", dat_l, vecs[0].exp_l);
    check("fresh_r", dat_r, vecs[0].exp_r);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
